// File: rtl/serial_mult_pkg.sv
// serial_mult_pkg: shared types and helpers for the bit-serial multiplier array.
//   - INT_W/FRAC_W defaults and the DATA_W/MAG_W derivations
//   - FSM state enum shared by the top level and its debug port
//   - round_pack(): round-half-up, overflow detect/saturate, sign-magnitude pack
// Optional feature macro used by the datapath: SERIAL_MULT_SAT_EN.
package serial_mult_pkg;

  localparam int INT_W_DEF  = 5;
  localparam int FRAC_W_DEF = 10;

  // round_pack works on fixed-size containers wide enough for any
  // accumulator up to 127 bits and any packed word up to 64 bits.
  localparam int RP_ACC_W  = 128;
  localparam int RP_WORD_W = 64;

  function automatic int data_w(input int int_w, input int frac_w);
    return 1 + int_w + frac_w;
  endfunction

  function automatic int mag_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 ovf;
    logic [RP_WORD_W-1:0] word;
  } rp_t;

  // Rounds the raw magnitude product back into the Q format, flags a result
  // that does not fit in mag_w bits, then saturates or wraps it. A zero
  // magnitude always carries a positive sign.
  function automatic rp_t round_pack(input logic [RP_ACC_W-1:0] acc,
                                     input logic                sign,
                                     input int                  frac_w,
                                     input int                  mag_w,
                                     input bit                  sat);
    logic [RP_ACC_W-1:0] q;
    logic [RP_ACC_W-1:0] mask;
    logic [RP_ACC_W-1:0] mag;
    rp_t                 r;
    q      = (acc + (128'd1 << (frac_w - 1))) >> frac_w;
    mask   = (128'd1 << mag_w) - 128'd1;
    r.ovf  = |(q & ~mask);
    mag    = (sat && r.ovf) ? mask : (q & mask);
    r.word = 64'(mag) | (64'(sign && (mag != '0)) << mag_w);
    return r;
  endfunction

endpackage

// File: rtl/serial_mult_array_if.sv
// serial_mult_array_if: handshake bundle of the multiplier array.
//   in_valid/in_ready/neuron_in      : neuron vector input (lane i at [i*DATA_W +: DATA_W])
//   weight_bit/weight_valid/weight_ready : serial weight stream, sign first then MSB first
//   out_valid/out_ready/out_data/out_ovf : rounded per-lane products
// Handshake rule for all three channels: a transfer happens on a rising clock
// edge where valid and ready are both 1; the producer keeps valid and its data
// stable until that edge, and ready never depends on the same-cycle valid.
// Modports: master = producer of inputs / consumer of results, slave = the array.
interface serial_mult_array_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] neuron_in;
  logic                    weight_bit;
  logic                    weight_valid;
  logic                    weight_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_ovf;

  modport master (
    output in_valid, neuron_in, weight_bit, weight_valid, out_ready,
    input  in_ready, weight_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, neuron_in, weight_bit, weight_valid, out_ready,
    output in_ready, weight_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/serial_mult_lane.sv
// serial_mult_lane: one neuron lane of the serial multiplier array.
//   load_i   : latch neuron_i and clear the accumulator
//   shift_i  : consume one weight magnitude bit (wbit_i)
//   round_i  : register the rounded/packed product into data_o/ovf_o
//   wsign_i  : weight sign shared by all lanes
//   data_o   : sign-magnitude product, ovf_o: overflow flag
// SERIAL_MULT_SAT_EN defined: overflow saturates the magnitude and raises ovf_o.
// Undefined: the magnitude wraps and ovf_o stays 0.
module serial_mult_lane
  import serial_mult_pkg::*;
#(
  parameter int  INT_W  = INT_W_DEF,
  parameter int  FRAC_W = FRAC_W_DEF,
  localparam int DATA_W = data_w(INT_W, FRAC_W),
  localparam int MAG_W  = mag_w(INT_W, FRAC_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] neuron_i,
  input  logic              shift_i,
  input  logic              wbit_i,
  input  logic              wsign_i,
  input  logic              round_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ovf_o
);

`ifdef SERIAL_MULT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Full product width: MAG_W x MAG_W magnitude plus one spare bit.
  localparam int ACC_W = 2 * MAG_W + 1;

  logic [DATA_W-1:0] neu_q, neu_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  rp_t               rp;
  logic              unused_word_hi;

  always_comb begin
    neu_d  = neu_q;
    acc_d  = acc_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    rp     = round_pack(128'(acc_q), neu_q[DATA_W-1] ^ wsign_i, FRAC_W, MAG_W, SAT_EN);
    if (load_i) begin
      neu_d = neuron_i;
      acc_d = '0;
    end else if (shift_i) begin
      // MSB-first shift-and-add of the neuron magnitude.
      acc_d = (acc_q << 1) + (wbit_i ? ACC_W'(neu_q[MAG_W-1:0]) : '0);
    end
    if (round_i) begin
      data_d = rp.word[DATA_W-1:0];
      ovf_d  = SAT_EN && rp.ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      neu_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      neu_q  <= neu_d;
      acc_q  <= acc_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign unused_word_hi = ^rp.word[RP_WORD_W-1:DATA_W];
  assign data_o         = data_q;
  assign ovf_o          = ovf_q;

endmodule

// File: rtl/serial_mult_array.sv
// serial_mult_array: LANES-wide bit-serial sign-magnitude multiplier.
//   clk, reset (synchronous, active-low)
//   bus     : serial_mult_array_if slave (neuron input, weight stream, results);
//             its LANES/DATA_W must match this module's parameters
//   state_o : current FSM state for observation
// Flow: IDLE latches the neuron vector, SHIFT consumes DATA_W weight bits
// (sign first), ROUND registers the products, DONE holds them until accepted.
// Optional feature macro: SERIAL_MULT_SAT_EN (saturate on overflow, see lane).
module serial_mult_array
  import serial_mult_pkg::*;
#(
  parameter int  INT_W  = INT_W_DEF,
  parameter int  FRAC_W = FRAC_W_DEF,
  parameter int  LANES  = 4,
  localparam int DATA_W = data_w(INT_W, FRAC_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_mult_array_if.slave   bus,
  output state_t               state_o
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wsign_q, wsign_d;
  logic               load, shift_en, round_en;
  logic               in_ready, weight_ready;

  logic [DATA_W-1:0]       lane_data [LANES];
  logic [LANES-1:0]        lane_ovf;
  logic [LANES*DATA_W-1:0] out_data_w;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wsign_d      = wsign_q;
    load         = 1'b0;
    shift_en     = 1'b0;
    round_en     = 1'b0;
    in_ready     = 1'b0;
    weight_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        weight_ready = 1'b1;
        if (bus.weight_valid) begin
          cnt_d = cnt_q + 1'b1;
          // The first bit of the stream is the weight sign, not magnitude.
          if (cnt_q == '0) wsign_d = bus.weight_bit;
          else             shift_en = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ROUND;
        end
      end
      ROUND: begin
        round_en = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wsign_q <= wsign_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    serial_mult_lane #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load),
      .neuron_i (bus.neuron_in[g*DATA_W +: DATA_W]),
      .shift_i  (shift_en),
      .wbit_i   (bus.weight_bit),
      .wsign_i  (wsign_q),
      .round_i  (round_en),
      .data_o   (lane_data[g]),
      .ovf_o    (lane_ovf[g])
    );
    assign out_data_w[g*DATA_W +: DATA_W] = lane_data[g];
  end

  assign bus.in_ready     = in_ready;
  assign bus.weight_ready = weight_ready;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_data     = out_data_w;
  assign bus.out_ovf      = lane_ovf;
  assign state_o          = state_q;

endmodule
